// File: rtl/a2i_sched_pkg.sv
// Shared types and defaults for the atoi-engine scheduler.
package a2i_sched_pkg;

    typedef enum logic [2:0] {
        AS_IDLE,
        AS_LOAD,
        AS_ARM,
        AS_RUN,
        AS_DONE
    } a2i_sched_sts;

    localparam int TMO_DEF = 64;

endpackage

// File: rtl/a2i_sched_rr_arb.sv
// Round-robin priority search: first requester above ptr, wrapping around.
// Latency: combinational; backpressure: none, the caller decides when to take the winner.
module rr_arb
    import a2i_sched_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]                      req,
    input  logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] ptr,
    output logic [NREQ-1:0]                      win,
    output logic                                 any
);

    localparam logic [NREQ-1:0] ONE = NREQ'(1);

    logic [NREQ-1:0] cand;

    always_comb begin
        win  = '0;
        any  = 1'b0;
        cand = '0;
        // Offsets 1..NREQ visit every requester once, the last-served one last.
        for (int off = 1; off <= NREQ; off++) begin
            cand = ONE << ((int'(ptr) + off) % NREQ);
            if (!any && ((req & cand) != '0)) begin
                win = cand;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/a2i_sched.sv
// Shares one atoi engine among NREQ requesters; sequences LOAD/ARM/RUN and reports result or timeout.
// Latency: done at t+4+k after req sampled at t; backpressure: req is a level held until its done pulse.
module a2i_sched
    import a2i_sched_pkg::*;
#(
    parameter int ASZ  = 17,
    parameter int DSZ  = 32,
    parameter int NREQ = 2,
    parameter int TMO  = TMO_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ-1:0]     hex,
    input  logic [NREQ*ASZ-1:0] addr,
    output logic [NREQ-1:0]     gnt,
    output logic [NREQ-1:0]     done,
    output logic                err,
    output logic [DSZ-1:0]      vo,
    output logic                a2i_en,
    output logic                a2i_hex,
    output logic [ASZ-1:0]      a2i_tib,
    input  logic                a2i_bsy,
    input  logic [DSZ-1:0]      a2i_vo
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TMO + 1);

    a2i_sched_sts    state;
    a2i_sched_sts    state_nxt;
    logic [PW-1:0]   ptr;
    logic [CW-1:0]   tmo_cnt;
    logic [NREQ-1:0] win;
    logic            any;
    logic [PW-1:0]   win_idx;
    logic [ASZ-1:0]  win_addr;
    logic            win_hex;
    logic            grant;
    logic            fin_ok;
    logic            fin_tmo;

    rr_arb #(.NREQ(NREQ)) u_arb (
        .req (req),
        .ptr (ptr),
        .win (win),
        .any (any)
    );

    always_comb begin
        win_idx  = '0;
        win_addr = '0;
        win_hex  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (win[i]) begin
                win_idx  = PW'(i);
                win_addr = addr[i*ASZ +: ASZ];
                win_hex  = hex[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= AS_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        fin_ok    = 1'b0;
        fin_tmo   = 1'b0;
        unique case (state)
            AS_IDLE: begin
                if (any) begin
                    grant     = 1'b1;
                    state_nxt = AS_LOAD;
                end
            end
            AS_LOAD: state_nxt = AS_ARM;
            AS_ARM:  state_nxt = AS_RUN;
            AS_RUN: begin
                // tmo_cnt counts busy RUN cycles already seen; a completion
                // in the same cycle the budget runs out still wins.
                if (!a2i_bsy) begin
                    fin_ok    = 1'b1;
                    state_nxt = AS_DONE;
                end else if (tmo_cnt == CW'(TMO)) begin
                    fin_tmo   = 1'b1;
                    state_nxt = AS_DONE;
                end
            end
            AS_DONE: state_nxt = AS_IDLE;
            default: state_nxt = AS_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt     <= '0;
            done    <= '0;
            err     <= 1'b0;
            vo      <= '0;
            a2i_en  <= 1'b0;
            a2i_hex <= 1'b0;
            a2i_tib <= '0;
            ptr     <= PW'(NREQ - 1);
            tmo_cnt <= '0;
        end else begin
            done   <= '0;
            a2i_en <= (state_nxt == AS_ARM) || (state_nxt == AS_RUN);

            if (grant) begin
                gnt     <= win;
                ptr     <= win_idx;
                a2i_tib <= win_addr;
                a2i_hex <= win_hex;
            end

            if (state == AS_ARM) begin
                tmo_cnt <= '0;
            end else if (state == AS_RUN) begin
                tmo_cnt <= tmo_cnt + CW'(1);
            end

            if (fin_ok) begin
                vo   <= a2i_vo;
                err  <= 1'b0;
                done <= gnt;
            end else if (fin_tmo) begin
                vo   <= '0;
                err  <= 1'b1;
                done <= gnt;
            end

            if (state == AS_DONE) begin
                gnt <= '0;
                err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_a2i_sched.sv
// Randomized scoreboard bench for a2i_sched with a behavioural atoi engine and memory.
`timescale 1ns/1ps
module tb_a2i_sched;

    localparam int ASZ  = 17;
    localparam int DSZ  = 32;
    localparam int NREQ = 2;
    localparam int TMO  = 8;
    localparam int NTOK = 10;

    logic                clk   = 1'b0;
    logic                rst_n = 1'b0;
    logic [NREQ-1:0]     req   = '0;
    logic [NREQ-1:0]     hex   = '0;
    logic [NREQ*ASZ-1:0] addr  = '0;
    logic [NREQ-1:0]     gnt;
    logic [NREQ-1:0]     done;
    logic                err;
    logic [DSZ-1:0]      vo;
    logic                a2i_en;
    logic                a2i_hex;
    logic [ASZ-1:0]      a2i_tib;
    logic                a2i_bsy;
    logic [DSZ-1:0]      a2i_vo;

    always #5 clk = ~clk;

    a2i_sched #(.ASZ(ASZ), .DSZ(DSZ), .NREQ(NREQ), .TMO(TMO)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .hex     (hex),
        .addr    (addr),
        .gnt     (gnt),
        .done    (done),
        .err     (err),
        .vo      (vo),
        .a2i_en  (a2i_en),
        .a2i_hex (a2i_hex),
        .a2i_tib (a2i_tib),
        .a2i_bsy (a2i_bsy),
        .a2i_vo  (a2i_vo)
    );

    typedef struct {
        int             who;
        logic [DSZ-1:0] vo;
        logic           err;
        int             lat;
        logic [ASZ-1:0] tib;
        logic           hx;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   last_served = NREQ - 1;
    int   rt[NREQ];

    string tok[NTOK] = '{"123", "-1f", "x", "", "42", "ff", "1234567", "12345678", "-9", "A0"};
    logic [7:0] mem [256];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int digit(input logic [7:0] c, input logic hx);
        if (c >= "0" && c <= "9") return int'(c - "0");
        if (hx && c >= "a" && c <= "f") return int'(c - "a") + 10;
        if (hx && c >= "A" && c <= "F") return int'(c - "A") + 10;
        return -1;
    endfunction

    // Value of the token and k = characters consumed including the terminator.
    function automatic void ref_atoi(input string s, input logic hx, output logic [DSZ-1:0] v, output int k);
        int i = 0;
        logic neg = 1'b0;
        logic [DSZ-1:0] acc = '0;
        if (s.len() > 0 && s[0] == "-") begin
            neg = 1'b1;
            i = 1;
        end
        while (i < s.len() && digit(s[i], hx) >= 0) begin
            acc = acc * (hx ? 32'd16 : 32'd10) + 32'(digit(s[i], hx));
            i++;
        end
        k = i + 1;
        v = neg ? -acc : acc;
    endfunction

    // Engine: reloads while en is low (bsy keeps its stale value), raises bsy
    // on the first enabled cycle, then consumes one character per cycle.
    logic [7:0]     eptr   = '0;
    logic [DSZ-1:0] eacc   = '0;
    logic           eneg   = 1'b0;
    logic           efirst = 1'b1;
    logic           estart = 1'b0;
    logic           ebsy   = 1'b0;
    logic           stuck  = 1'b0;

    assign a2i_bsy = ebsy | stuck;
    assign a2i_vo  = eneg ? -eacc : eacc;

    always @(posedge clk) begin
        if (!a2i_en) begin
            eptr   <= a2i_tib[7:0];
            eacc   <= '0;
            eneg   <= 1'b0;
            efirst <= 1'b1;
            estart <= 1'b0;
        end else if (!estart) begin
            estart <= 1'b1;
            ebsy   <= 1'b1;
        end else if (ebsy) begin
            eptr   <= eptr + 8'd1;
            efirst <= 1'b0;
            if (efirst && mem[eptr] == "-") eneg <= 1'b1;
            else if (digit(mem[eptr], a2i_hex) >= 0)
                eacc <= eacc * (a2i_hex ? 32'd16 : 32'd10) + 32'(digit(mem[eptr], a2i_hex));
            else ebsy <= 1'b0;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every done pulse and checks protocol invariants.
    exp_t            e;
    int              gnt_cyc  = 0;
    int              done_cyc = -100;
    logic [NREQ-1:0] p_gnt    = '0;
    logic [NREQ-1:0] p_done   = '0;
    logic            p_en     = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            p_gnt    = '0;
            p_done   = '0;
            p_en     = 1'b0;
            done_cyc = -100;
        end else begin
            if (gnt != '0 && p_gnt == '0) begin
                gnt_cyc = cyc;
                chk("gnt_onehot", 64'($countones(gnt)), 64'd1);
                chk("turnaround_ge2", 64'(cyc - done_cyc >= 2), 64'd1);
            end
            if (a2i_en && p_en) chk("gnt_stable", 64'(gnt), 64'(p_gnt));
            if (p_done != '0) begin
                chk("done_single", 64'(done), 64'd0);
                chk("err_cleared", 64'(err), 64'd0);
            end
            if (done != '0) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: done=%b with nothing expected", done);
                end else begin
                    e = sb.pop_front();
                    chk("done_who", 64'(done), 64'd1 << e.who);
                    chk("gnt_at_done", 64'(gnt), 64'd1 << e.who);
                    chk("vo", 64'(vo), 64'(e.vo));
                    chk("err", 64'(err), 64'(e.err));
                    chk("latency", 64'(cyc - gnt_cyc), 64'(e.lat));
                    chk("a2i_tib", 64'(a2i_tib), 64'(e.tib));
                    chk("a2i_hex", 64'(a2i_hex), 64'(e.hx));
                end
                done_cyc = cyc;
            end
            p_gnt  = gnt;
            p_done = done;
            p_en   = a2i_en;
        end
    end

    // Round-robin order over the requesters in mask, starting after the last served.
    task automatic push_round(input logic [NREQ-1:0] mask, input logic [NREQ-1:0] hx, input logic stk);
        logic [DSZ-1:0] v;
        int   k;
        int   n;
        int   nl;
        exp_t x;
        nl = last_served;
        for (int i = 0; i < NREQ; i++) begin
            addr[i*ASZ +: ASZ] = {9'($urandom_range(0, 511)), 8'(rt[i] * 16)};
            hex[i] = hx[i];
        end
        for (int off = 1; off <= NREQ; off++) begin
            n = (last_served + off) % NREQ;
            if (mask[n]) begin
                ref_atoi(tok[rt[n]], hx[n], v, k);
                if (stk) k = TMO + 1;
                x.who = n;
                x.hx  = hx[n];
                x.tib = addr[n*ASZ +: ASZ];
                if (k > TMO) begin
                    x.vo = '0; x.err = 1'b1; x.lat = 3 + TMO;
                end else begin
                    x.vo = v;  x.err = 1'b0; x.lat = 3 + k;
                end
                sb.push_back(x);
                nl = n;
            end
        end
        last_served = nl;
        stuck = stk;
        req   = mask;
    endtask

    task automatic run_round(input logic [NREQ-1:0] mask, input logic [NREQ-1:0] hx, input logic stk);
        int n = 0;
        push_round(mask, hx, stk);
        while (req != '0 && n < 200) begin
            @(negedge clk);
            req = req & ~done;
            n++;
        end
        if (req != '0) begin
            checks++;
            errors++;
            $display("FAIL round_timeout: req=%b still pending after %0d cycles", req, n);
            req = '0;
            sb.delete();
            repeat (40) @(negedge clk);
        end
        stuck = 1'b0;
    endtask

    initial begin
        string s;
        int    n;
        for (int a = 0; a < 256; a++) mem[a] = 8'h00;
        for (int j = 0; j < NTOK; j++) begin
            s = tok[j];
            for (int c = 0; c < s.len(); c++) mem[j*16 + c] = s[c];
        end

        repeat (3) @(negedge clk);
        #1;
        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_vo", 64'(vo), 64'd0);
        chk("rst_en", 64'(a2i_en), 64'd0);
        chk("rst_hex", 64'(a2i_hex), 64'd0);
        chk("rst_tib", 64'(a2i_tib), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        rt[0] = 0; rt[1] = 1;
        run_round(2'b01, 2'b00, 1'b0);          // "123" decimal
        run_round(2'b10, 2'b10, 1'b0);          // "-1f" hex -> -31
        rt[0] = 4; rt[1] = 5;
        run_round(2'b11, 2'b00, 1'b0);          // contention: 0 then 1
        run_round(2'b11, 2'b11, 1'b0);          // then 0, 1 again
        rt[1] = 4;
        run_round(2'b10, 2'b00, 1'b1);          // engine stuck busy -> timeout
        rt[0] = 4;
        run_round(2'b01, 2'b00, 1'b0);          // next job after timeout
        rt[0] = 2; rt[1] = 3;
        run_round(2'b11, 2'b00, 1'b0);          // "x" and "" -> minimum latency
        rt[0] = 6; rt[1] = 7;
        run_round(2'b11, 2'b00, 1'b0);          // k=TMO completes, k=TMO+1 times out

        // Reset in the middle of a "123" conversion.
        rt[0] = 0;
        push_round(2'b01, 2'b00, 1'b0);
        n = 0;
        while (!a2i_en && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("pre_reset_en", 64'(a2i_en), 64'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_en", 64'(a2i_en), 64'd0);
        chk("midrst_gnt", 64'(gnt), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_vo", 64'(vo), 64'd0);
        sb.delete();
        req = '0;
        last_served = NREQ - 1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rt[0] = 0; rt[1] = 1;
        run_round(2'b11, 2'b10, 1'b0);          // requester 0 first after reset

        repeat (40) begin
            for (int i = 0; i < NREQ; i++) rt[i] = int'($urandom_range(0, NTOK - 1));
            run_round(NREQ'($urandom_range(1, (1 << NREQ) - 1)),
                      NREQ'($urandom_range(0, (1 << NREQ) - 1)),
                      1'($urandom_range(0, 9) == 0));
        end

        repeat (5) @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
